// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: mem_op bit layout,
// size codes, FSM state encoding and the legal XLEN values.
// Pure definitions, no logic, no latency, no flow control.
package mem_stage_lsu_pkg;

  // Legal register widths.
  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  // mem_op = {is_load, is_store, size[1:0], is_unsigned}
  localparam int MEMOP_W        = 5;
  localparam int MEMOP_LOAD     = 4;
  localparam int MEMOP_STORE    = 3;
  localparam int MEMOP_SIZE_HI  = 2;
  localparam int MEMOP_SIZE_LO  = 1;
  localparam int MEMOP_UNSIGNED = 0;

  localparam logic [1:0] MEM_SZ_B = 2'd0;
  localparam logic [1:0] MEM_SZ_H = 2'd1;
  localparam logic [1:0] MEM_SZ_W = 2'd2;
  localparam logic [1:0] MEM_SZ_D = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  // A doubleword cannot exist on a 32-bit datapath; it degrades to a word.
  function automatic logic [1:0] eff_size(input logic [1:0] size, input int xlen);
    return ((size == MEM_SZ_D) && (xlen == XLEN_32)) ? MEM_SZ_W : size;
  endfunction

  function automatic logic [3:0] size_len(input logic [1:0] size);
    logic [3:0] len;
    case (size)
      MEM_SZ_B: len = 4'd1;
      MEM_SZ_H: len = 4'd2;
      MEM_SZ_W: len = 4'd4;
      default:  len = 4'd8;
    endcase
    return len;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      MEM_SZ_B: mask = 3'b000;
      MEM_SZ_H: mask = 3'b001;
      MEM_SZ_W: mask = 3'b011;
      default:  mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Request/response bus between the load/store unit and the memory controller.
// Request: valid/ready handshake, fields stable while valid && !ready.
// Response: single-cycle mem_resp_valid strobe, no backpressure.
// Ports: mem_req_valid/ready/we/addr/wdata/len, mem_resp_valid/data.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [3:0]        mem_req_len;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_data;

  // LSU side.
  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_len,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  // Memory controller side.
  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_len,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/mem_stage_lsu_load_ext.sv
// Sign/zero extension of right-aligned load data to XLEN by access size.
// Latency: combinational.
// Backpressure: none.
// Ports: i_data (raw response), i_size (effective size code), i_unsigned,
//        o_data (extended result).
module lsu_load_ext
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_byte;
  logic [XLEN-1:0] w_half;
  logic [XLEN-1:0] w_word;

  assign w_byte = {{(XLEN-8){i_data[7] & ~i_unsigned}}, i_data[7:0]};
  assign w_half = {{(XLEN-16){i_data[15] & ~i_unsigned}}, i_data[15:0]};

  // A word only needs extending when the register is wider than 32 bits
  // (LW vs LWU on a 64-bit datapath).
  generate
    if (XLEN > 32) begin : g_word_ext
      assign w_word = {{(XLEN-32){i_data[31] & ~i_unsigned}}, i_data[31:0]};
    end else begin : g_word_full
      assign w_word = i_data;
    end
  endgenerate

  always_comb begin
    o_data = i_data;
    case (i_size)
      MEM_SZ_B: o_data = w_byte;
      MEM_SZ_H: o_data = w_half;
      MEM_SZ_W: o_data = w_word;
      default:  o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: passes non-memory ops through and sequences loads/stores
// against the memory controller. Latency: 0 for non-memory ops, >=2 cycles
// for memory ops. Backpressure: stall_from_mem holds ex_mem while an access
// is outstanding; the request waits on mem_req_ready; rdy_in low freezes it.
// Ports: clk_in/rst_in/rdy_in; in_* from ex_mem; out_* to mem_wb; fwd_* to ID;
//        stall_from_mem to stallctrl; mem_bus (master) to the memory controller.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead
//           of issuing them; otherwise out_misalign is tied low.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN       = 32,  // 32 or 64 only
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]       in_rd_data,
  input  logic                  in_rd_we,
  input  logic [MEMOP_W-1:0]    in_mem_op,
  input  logic [ADDR_W-1:0]     in_mem_addr,
  input  logic [XLEN-1:0]       in_store_data,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [XLEN-1:0]       out_rd_data,
  output logic                  out_rd_we,
  output logic                  out_misalign,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  stall_from_mem,
  mem_stage_lsu_if.master       mem_bus
);

  lsu_state_t      r_state;
  logic [XLEN-1:0] r_result;

  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_mem;
  logic            w_unsigned;
  logic [1:0]      w_size;
  logic [3:0]      w_len;
  logic [XLEN-1:0] w_ext;
  logic            w_trap;

  assign w_is_load  = in_mem_op[MEMOP_LOAD];
  assign w_is_store = in_mem_op[MEMOP_STORE];
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_unsigned = in_mem_op[MEMOP_UNSIGNED];
  assign w_size     = eff_size(in_mem_op[MEMOP_SIZE_HI:MEMOP_SIZE_LO], XLEN);
  assign w_len      = size_len(w_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = w_is_mem && ((in_mem_addr[2:0] & align_mask(w_size)) != 3'b000);
`else
  assign w_trap = 1'b0;
`endif

  lsu_load_ext #(
    .XLEN (XLEN)
  ) u_load_ext (
    .i_data     (mem_bus.mem_resp_data),
    .i_size     (w_size),
    .i_unsigned (w_unsigned),
    .o_data     (w_ext)
  );

  // The instruction in ex_mem is held by our stall from the IDLE issue cycle
  // through DONE, so the in_* fields remain valid for the whole sequence.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= LSU_IDLE;
      r_result <= '0;
    end else if (rdy_in) begin
      case (r_state)
        LSU_IDLE: begin
          if (w_trap) begin
            r_state <= LSU_DONE;
          end else if (w_is_mem) begin
            r_state <= mem_bus.mem_req_ready ? LSU_WAIT : LSU_REQ;
          end
        end
        LSU_REQ: begin
          if (mem_bus.mem_req_ready) begin
            r_state <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (mem_bus.mem_resp_valid) begin
            if (w_is_load) begin
              r_result <= w_ext;
            end
            r_state <= LSU_DONE;
          end
        end
        default: begin
          r_state <= LSU_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    out_rd_addr           = in_rd_addr;
    out_rd_data           = in_rd_data;
    out_rd_we             = 1'b0;
    out_misalign          = 1'b0;
    stall_from_mem        = 1'b0;
    mem_bus.mem_req_valid = 1'b0;
    mem_bus.mem_req_we    = w_is_store;
    mem_bus.mem_req_addr  = in_mem_addr;
    mem_bus.mem_req_wdata = in_store_data;
    mem_bus.mem_req_len   = w_len;

    case (r_state)
      LSU_IDLE: begin
        if (w_is_mem) begin
          stall_from_mem        = 1'b1;
          mem_bus.mem_req_valid = rdy_in & ~w_trap;
        end else begin
          out_rd_we = in_rd_we;
        end
      end
      LSU_REQ: begin
        stall_from_mem        = 1'b1;
        mem_bus.mem_req_valid = rdy_in;
      end
      LSU_WAIT: begin
        stall_from_mem = 1'b1;
      end
      default: begin
        // DONE: a trapped access or a store retires without a register write.
        out_misalign = w_trap;
        if (w_is_load && !w_trap) begin
          out_rd_data = r_result;
          out_rd_we   = in_rd_we;
        end
      end
    endcase

    // Everything visible is forced low for as long as reset is asserted.
    if (rst_in) begin
      out_rd_addr           = '0;
      out_rd_data           = '0;
      out_rd_we             = 1'b0;
      out_misalign          = 1'b0;
      stall_from_mem        = 1'b0;
      mem_bus.mem_req_valid = 1'b0;
      mem_bus.mem_req_we    = 1'b0;
      mem_bus.mem_req_addr  = '0;
      mem_bus.mem_req_wdata = '0;
      mem_bus.mem_req_len   = '0;
    end
  end

  assign fwd_valid = out_rd_we && (out_rd_addr != '0);
  assign fwd_addr  = out_rd_addr;
  assign fwd_data  = out_rd_data;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a 32-bit and a 64-bit instance driven by
// hand-written vectors, memory controller played directly by the stimulus.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_mem_stage_lsu;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_LB   = 5'b10000;
  localparam logic [4:0] OP_LHU  = 5'b10011;
  localparam logic [4:0] OP_LW   = 5'b10100;
  localparam logic [4:0] OP_LWU  = 5'b10101;
  localparam logic [4:0] OP_LD   = 5'b10110;
  localparam logic [4:0] OP_SW   = 5'b01100;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   stall_cnt;

  // 32-bit instance signals
  logic        a_rdy, a_rd_we, a_o_rd_we, a_mis, a_fv, a_stall;
  logic [4:0]  a_rd_addr, a_op, a_o_rd_addr, a_fa;
  logic [31:0] a_rd_data, a_addr, a_sdata, a_o_rd_data, a_fd;

  // 64-bit instance signals
  logic        b_rdy, b_rd_we, b_o_rd_we, b_mis, b_fv, b_stall;
  logic [4:0]  b_rd_addr, b_op, b_o_rd_addr, b_fa;
  logic [63:0] b_rd_data, b_sdata, b_o_rd_data, b_fd;
  logic [31:0] b_addr;

  mem_stage_lsu_if #(.ADDR_W(32), .XLEN(32)) bus32 ();
  mem_stage_lsu_if #(.ADDR_W(32), .XLEN(64)) bus64 ();

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5)) dut32 (
    .clk_in(clk), .rst_in(rst), .rdy_in(a_rdy),
    .in_rd_addr(a_rd_addr), .in_rd_data(a_rd_data), .in_rd_we(a_rd_we),
    .in_mem_op(a_op), .in_mem_addr(a_addr), .in_store_data(a_sdata),
    .out_rd_addr(a_o_rd_addr), .out_rd_data(a_o_rd_data), .out_rd_we(a_o_rd_we),
    .out_misalign(a_mis), .fwd_valid(a_fv), .fwd_addr(a_fa), .fwd_data(a_fd),
    .stall_from_mem(a_stall), .mem_bus(bus32.master)
  );

  mem_stage_lsu #(.XLEN(64), .ADDR_W(32), .REG_ADDR_W(5)) dut64 (
    .clk_in(clk), .rst_in(rst), .rdy_in(b_rdy),
    .in_rd_addr(b_rd_addr), .in_rd_data(b_rd_data), .in_rd_we(b_rd_we),
    .in_mem_op(b_op), .in_mem_addr(b_addr), .in_store_data(b_sdata),
    .out_rd_addr(b_o_rd_addr), .out_rd_data(b_o_rd_data), .out_rd_we(b_o_rd_we),
    .out_misalign(b_mis), .fwd_valid(b_fv), .fwd_addr(b_fa), .fwd_data(b_fd),
    .stall_from_mem(b_stall), .mem_bus(bus64.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Load on the 32-bit instance: accepted at once, response one cycle later.
  task automatic do_load32(input string tag, input logic [4:0] op, input logic [31:0] addr,
                           input logic [31:0] resp, input logic [3:0] exp_len,
                           input logic [31:0] exp_data);
    a_op = op; a_addr = addr; a_rd_addr = 5'd4; a_rd_we = 1'b1;
    bus32.mem_req_ready = 1'b1;
    sample();
    expect_eq({tag, "_req_valid"}, 64'(bus32.mem_req_valid), 64'd1);
    expect_eq({tag, "_len"}, 64'(bus32.mem_req_len), 64'(exp_len));
    next_cyc();
    bus32.mem_req_ready = 1'b0; bus32.mem_resp_valid = 1'b1; bus32.mem_resp_data = resp;
    sample();
    expect_eq({tag, "_wait_stall"}, 64'(a_stall), 64'd1);
    next_cyc();
    bus32.mem_resp_valid = 1'b0;
    sample();
    expect_eq({tag, "_data"}, 64'(a_o_rd_data), 64'(exp_data));
    expect_eq({tag, "_we"}, 64'(a_o_rd_we), 64'd1);
    expect_eq({tag, "_misalign"}, 64'(a_mis), 64'd0);
    next_cyc();
    a_op = OP_NONE;
  endtask

  task automatic do_load64(input string tag, input logic [4:0] op, input logic [31:0] addr,
                           input logic [63:0] resp, input logic [3:0] exp_len,
                           input logic [63:0] exp_data);
    b_op = op; b_addr = addr; b_rd_addr = 5'd6; b_rd_we = 1'b1;
    bus64.mem_req_ready = 1'b1;
    sample();
    expect_eq({tag, "_len"}, 64'(bus64.mem_req_len), 64'(exp_len));
    next_cyc();
    bus64.mem_req_ready = 1'b0; bus64.mem_resp_valid = 1'b1; bus64.mem_resp_data = resp;
    next_cyc();
    bus64.mem_resp_valid = 1'b0;
    sample();
    expect_eq({tag, "_data"}, b_o_rd_data, exp_data);
    expect_eq({tag, "_stall"}, 64'(b_stall), 64'd0);
    next_cyc();
    b_op = OP_NONE;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; stall_cnt = 0;
    rst = 1'b1;
    a_rdy = 1'b1; a_rd_addr = 5'd3; a_rd_data = 32'h55; a_rd_we = 1'b1;
    a_op = OP_LB; a_addr = 32'h100; a_sdata = 32'h0;
    b_rdy = 1'b1; b_rd_addr = 5'd0; b_rd_data = 64'h0; b_rd_we = 1'b0;
    b_op = OP_NONE; b_addr = 32'h0; b_sdata = 64'h0;
    bus32.mem_req_ready = 1'b1; bus32.mem_resp_valid = 1'b0; bus32.mem_resp_data = 32'h0;
    bus64.mem_req_ready = 1'b0; bus64.mem_resp_valid = 1'b0; bus64.mem_resp_data = 64'h0;

    // Reset: a pending load on the inputs must not show through.
    sample();
    expect_eq("rst_out_data", 64'(a_o_rd_data), 64'h0);
    expect_eq("rst_out_we", 64'(a_o_rd_we), 64'd0);
    expect_eq("rst_stall", 64'(a_stall), 64'd0);
    expect_eq("rst_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    expect_eq("rst_fwd_valid", 64'(a_fv), 64'd0);
    next_cyc();
    rst = 1'b0;

    // Non-memory pass-through (addi x5 = 0x1234).
    a_op = OP_NONE; a_rd_addr = 5'd5; a_rd_data = 32'h1234; a_rd_we = 1'b1;
    bus32.mem_req_ready = 1'b0;
    sample();
    expect_eq("alu_data", 64'(a_o_rd_data), 64'h1234);
    expect_eq("alu_fwd_valid", 64'(a_fv), 64'd1);
    expect_eq("alu_fwd_addr", 64'(a_fa), 64'd5);
    expect_eq("alu_stall", 64'(a_stall), 64'd0);
    expect_eq("alu_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    next_cyc();
    a_rd_addr = 5'd0;
    sample();
    expect_eq("x0_we", 64'(a_o_rd_we), 64'd1);
    expect_eq("x0_fwd_valid", 64'(a_fv), 64'd0);

    // LB x3 @0x100, accepted immediately, response two cycles later.
    next_cyc();
    a_op = OP_LB; a_rd_addr = 5'd3; a_rd_data = 32'h100; a_addr = 32'h100;
    bus32.mem_req_ready = 1'b1;
    stall_cnt = 0;
    sample();
    expect_eq("lb_req_valid", 64'(bus32.mem_req_valid), 64'd1);
    expect_eq("lb_req_we", 64'(bus32.mem_req_we), 64'd0);
    expect_eq("lb_req_len", 64'(bus32.mem_req_len), 64'd1);
    expect_eq("lb_req_addr", 64'(bus32.mem_req_addr), 64'h100);
    stall_cnt += int'(a_stall);
    next_cyc();
    bus32.mem_req_ready = 1'b0;
    sample();
    expect_eq("lb_wait_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    stall_cnt += int'(a_stall);
    next_cyc();
    bus32.mem_resp_valid = 1'b1; bus32.mem_resp_data = 32'h0000_00F0;
    sample();
    stall_cnt += int'(a_stall);
    next_cyc();
    bus32.mem_resp_valid = 1'b0;
    sample();
    stall_cnt += int'(a_stall);
    expect_eq("lb_data", 64'(a_o_rd_data), 64'hFFFF_FFF0);
    expect_eq("lb_we", 64'(a_o_rd_we), 64'd1);
    expect_eq("lb_fwd_valid", 64'(a_fv), 64'd1);
    expect_eq("lb_fwd_data", 64'(a_fd), 64'hFFFF_FFF0);
    expect_eq("lb_stall_cycles", 64'(stall_cnt), 64'd3);

    // LHU x8 @0x104 with a slow controller, a stray response and an rdy_in gap.
    next_cyc();
    a_op = OP_LHU; a_rd_addr = 5'd8; a_addr = 32'h104; bus32.mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus32.mem_resp_valid = 1'b1; bus32.mem_resp_data = 32'h5555_5555;
      end
      sample();
      expect_eq($sformatf("lhu_hold%0d_valid", i), 64'(bus32.mem_req_valid), 64'd1);
      expect_eq($sformatf("lhu_hold%0d_addr", i), 64'(bus32.mem_req_addr), 64'h104);
      expect_eq($sformatf("lhu_hold%0d_len", i), 64'(bus32.mem_req_len), 64'd2);
      expect_eq($sformatf("lhu_hold%0d_stall", i), 64'(a_stall), 64'd1);
      next_cyc();
    end
    bus32.mem_resp_valid = 1'b0;
    a_rdy = 1'b0; bus32.mem_req_ready = 1'b1;
    sample();
    expect_eq("lhu_frozen_valid", 64'(bus32.mem_req_valid), 64'd0);
    expect_eq("lhu_frozen_stall", 64'(a_stall), 64'd1);
    next_cyc();
    a_rdy = 1'b1;
    sample();
    expect_eq("lhu_resume_valid", 64'(bus32.mem_req_valid), 64'd1);
    next_cyc();
    bus32.mem_req_ready = 1'b0; bus32.mem_resp_valid = 1'b1; bus32.mem_resp_data = 32'h1234_ABCD;
    sample();
    expect_eq("lhu_wait_valid", 64'(bus32.mem_req_valid), 64'd0);
    next_cyc();
    bus32.mem_resp_valid = 1'b0;
    sample();
    expect_eq("lhu_data", 64'(a_o_rd_data), 64'h0000_ABCD);
    expect_eq("lhu_stall", 64'(a_stall), 64'd0);

    // SW 0xDEADBEEF @0x200.
    next_cyc();
    a_op = OP_SW; a_rd_addr = 5'd7; a_rd_we = 1'b1; a_addr = 32'h200; a_sdata = 32'hDEAD_BEEF;
    bus32.mem_req_ready = 1'b1;
    sample();
    expect_eq("sw_req_we", 64'(bus32.mem_req_we), 64'd1);
    expect_eq("sw_req_len", 64'(bus32.mem_req_len), 64'd4);
    expect_eq("sw_req_wdata", 64'(bus32.mem_req_wdata), 64'hDEAD_BEEF);
    next_cyc();
    bus32.mem_req_ready = 1'b0; bus32.mem_resp_valid = 1'b1; bus32.mem_resp_data = 32'h0;
    next_cyc();
    bus32.mem_resp_valid = 1'b0;
    sample();
    expect_eq("sw_done_we", 64'(a_o_rd_we), 64'd0);
    expect_eq("sw_done_fwd_valid", 64'(a_fv), 64'd0);
    expect_eq("sw_done_stall", 64'(a_stall), 64'd0);
    next_cyc();
    a_op = OP_NONE;

    // Doubleword on a 32-bit datapath degrades to a word.
    do_load32("ld_on32", OP_LD, 32'h110, 32'h8000_0001, 4'd4, 32'h8000_0001);

    // Misaligned LW @0x102.
`ifdef LSU_MISALIGN_TRAP_EN
    a_op = OP_LW; a_addr = 32'h102; a_rd_addr = 5'd4; a_rd_we = 1'b1;
    bus32.mem_req_ready = 1'b1;
    sample();
    expect_eq("mis_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    expect_eq("mis_issue_stall", 64'(a_stall), 64'd1);
    next_cyc();
    bus32.mem_req_ready = 1'b0;
    sample();
    expect_eq("mis_flag", 64'(a_mis), 64'd1);
    expect_eq("mis_we", 64'(a_o_rd_we), 64'd0);
    expect_eq("mis_done_stall", 64'(a_stall), 64'd0);
    next_cyc();
    a_op = OP_NONE;
`else
    do_load32("lw_unaligned", OP_LW, 32'h102, 32'h1234_5678, 4'd4, 32'h1234_5678);
`endif

    // Reset raised while waiting for a load response.
    a_op = OP_LB; a_addr = 32'h108; a_rd_addr = 5'd3; a_rd_data = 32'h108;
    bus32.mem_req_ready = 1'b1;
    next_cyc();
    bus32.mem_req_ready = 1'b0;
    rst = 1'b1;
    sample();
    expect_eq("rstw_out_data", 64'(a_o_rd_data), 64'h0);
    expect_eq("rstw_stall", 64'(a_stall), 64'd0);
    expect_eq("rstw_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    #1;
    rst = 1'b0;
    a_op = OP_NONE; a_rd_addr = 5'd9; a_rd_data = 32'h77; a_rd_we = 1'b1;
    #1;
    expect_eq("rstw_idle_we", 64'(a_o_rd_we), 64'd1);
    expect_eq("rstw_idle_data", 64'(a_o_rd_data), 64'h77);
    expect_eq("rstw_idle_stall", 64'(a_stall), 64'd0);
    next_cyc();

    // 64-bit datapath word/doubleword loads.
    do_load64("lw64", OP_LW, 32'h300, 64'h0000_0000_8000_0000, 4'd4, 64'hFFFF_FFFF_8000_0000);
    do_load64("lwu64", OP_LWU, 32'h304, 64'h0000_0000_8000_0000, 4'd4, 64'h0000_0000_8000_0000);
    do_load64("ld64", OP_LD, 32'h308, 64'h8123_4567_89AB_CDEF, 4'd8, 64'h8123_4567_89AB_CDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the pipeline MEM stage. Sits between ex_mem and mem_wb.
- Non-memory ops pass through with zero latency.
- Loads and stores are sequenced by a small FSM against the memory controller using a valid/ready request handshake and a response strobe.
- Output is generalised to XLEN 32/64 with correct per-size byte lengths and sign/zero extension. Provides the forward path to ID and the stall signal to stallctrl.

Parameters:
- XLEN, 32, data/register width; 32 or 64 only.
- ADDR_W, 32, memory address width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous reset, active-high.
- rdy_in  in  1  global ready; low freezes FSM and suppresses requests.
- in_rd_addr  in  REG_ADDR_W  destination register from ex_mem.
- in_rd_data  in  XLEN  ALU result from ex_mem.
- in_rd_we  in  1  register write enable from ex_mem.
- in_mem_op  in  5  {is_load, is_store, size[1:0], is_unsigned}; all-zero means non-memory.
- in_mem_addr  in  ADDR_W  effective address.
- in_store_data  in  XLEN  store data, right-aligned.
- out_rd_addr  out  REG_ADDR_W  to mem_wb.
- out_rd_data  out  XLEN  to mem_wb.
- out_rd_we  out  1  to mem_wb.
- out_misalign  out  1  misaligned-access flag (feature only; else tied 0).
- fwd_valid  out  1  forward to ID valid.
- fwd_addr  out  REG_ADDR_W  forward register index.
- fwd_data  out  XLEN  forward data.
- stall_from_mem  out  1  to stallctrl.
- mem_req_valid  out  1  request to mem ctrl.
- mem_req_ready  in  1  mem ctrl accepts request this cycle.
- mem_req_we  out  1  1=store, 0=load.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_wdata  out  XLEN  store data.
- mem_req_len  out  4  byte count (1, 2, 4 or 8).
- mem_resp_valid  in  1  one-cycle strobe: load data or store completion.
- mem_resp_data  in  XLEN  load data, right-aligned.

Behaviour:
- Reset (async): state=IDLE, result register=0. All outputs are 0 while rst_in is high.
- States: IDLE, REQ, WAIT, DONE.
- Size/length: size 0/1/2/3 gives len 1/2/4/8. Size 3 with XLEN=32 is treated as size 2.
- Non-memory op in IDLE: out_* = in_*, stall=0, no request (combinational).
- Memory op in IDLE:
  - stall=1 and mem_req_valid=1 in the same cycle.
  - If mem_req_ready, go to WAIT; else go to REQ.
- REQ: hold mem_req_valid and all request fields stable; stall=1. On mem_req_ready, go to WAIT.
- WAIT: stall=1, mem_req_valid=0. On mem_resp_valid, register the extended load data (loads only) and go to DONE.
- Extension: low 8·len bits of mem_resp_data. is_unsigned selects zero extension; otherwise sign extension from bit 8·len−1. Size 2 on XLEN=64 sign-extends (LW) or zero-extends (LWU).
- DONE (exactly one cycle), stall=0:
  - Load: out_rd_data=registered result, out_rd_we=in_rd_we, out_rd_addr=in_rd_addr.
  - Store: out_rd_we=0.
  - Next state IDLE. Upstream advances at this edge, so the next input is a new instruction.
- mem_resp_valid in IDLE or REQ is ignored. mem_req_ready outside a request is ignored.
- rdy_in=0: state and result register hold, mem_req_valid=0, stall_from_mem held at its current-state value.
- Forwarding: fwd_valid = out_rd_we and out_rd_addr != 0. fwd_addr/fwd_data mirror out_rd_addr/out_rd_data. Forwarding to x0 is suppressed.
- Reset mid-operation returns to IDLE immediately. The in-flight mem ctrl transaction is abandoned; mem ctrl is reset by the same rst_in.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a memory op whose address is not aligned to len issues no request. IDLE goes straight to DONE with out_misalign=1, out_rd_we=0, stall=1 for the IDLE cycle only.
- Undefined: misaligned requests are issued unchanged (mem ctrl moves bytes serially) and out_misalign is tied 0.

Decomposition:
- Shared package (define file):
  - mem_op field positions and size codes MEM_SZ_B/H/W/D.
  - State encodings LSU_IDLE/REQ/WAIT/DONE.
  - XLEN legal values.
- Sub-module lsu_load_ext: combinational extension of mem_resp_data by size/is_unsigned, parametrised on XLEN.

Test Plan:
- Non-memory op (addi x5=0x1234, we=1) -> same-cycle out_rd_data=0x1234, fwd_valid=1, fwd_addr=5, stall=0, mem_req_valid=0.
- LB x3, addr 0x100, ready=1 immediately, resp 0x000000F0 two cycles later -> out_rd_data=0xFFFFFFF0 in DONE; stall high for exactly 3 cycles.
- LHU with ready delayed 4 cycles -> mem_req_valid/addr/len=2 held stable throughout REQ; result 0x0000ABCD from resp 0x1234ABCD.
- SW 0xDEADBEEF to 0x200 -> mem_req_we=1, len=4, wdata=0xDEADBEEF; DONE has out_rd_we=0, fwd_valid=0.
- XLEN=64: LW resp 0x80000000 -> 0xFFFFFFFF80000000; LWU -> 0x0000000080000000; LD len=8.
- rst_in raised during WAIT -> next observation IDLE, all outputs 0. With LSU_MISALIGN_TRAP_EN, LW @0x102 -> no request, out_misalign=1, out_rd_we=0.
